// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared definitions for the pipeline control slice: the
//                memory-wait controller state encoding, register address
//                width and the register-zero constant.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_pkg;

  // Register file address width (32 architectural registers)
  localparam int unsigned c_REG_ADDR_W = 5;

  // Register $zero: never a real destination, so it can never create a hazard
  localparam logic [c_REG_ADDR_W-1:0] c_REG_ZERO = '0;

  // Data-memory wait controller states
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } ctrl_state_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_detect
//  Description : Combinational load-use hazard detector. Flags when the load
//                in EX writes a register that the instruction in ID reads.
//  Ports       : i_ifid_rs_addr   - rs of the instruction in ID
//                i_ifid_rt_addr   - rt of the instruction in ID
//                i_idex_rt_addr   - destination of the instruction in EX
//                i_idex_mem_read  - instruction in EX is a load
//                o_load_use       - load-use hazard present
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_detect
  import cpu_pkg::*;
(
  input  logic [c_REG_ADDR_W-1:0] i_ifid_rs_addr,
  input  logic [c_REG_ADDR_W-1:0] i_ifid_rt_addr,
  input  logic [c_REG_ADDR_W-1:0] i_idex_rt_addr,
  input  logic                    i_idex_mem_read,
  output logic                    o_load_use
);

  logic w_dest_valid;
  logic w_addr_match;

  // A load into $zero is discarded by the register file, so it is not a hazard
  assign w_dest_valid = (i_idex_rt_addr != c_REG_ZERO);
  assign w_addr_match = (i_idex_rt_addr == i_ifid_rs_addr) ||
                        (i_idex_rt_addr == i_ifid_rt_addr);
  assign o_load_use   = i_idex_mem_read && w_dest_valid && w_addr_match;

endmodule : hazard_detect
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_ctrl
//  Description : Pipeline stall/flush controller. Combines a data-memory wait
//                FSM (RUN/WAIT/ERR with timeout), load-use hazard detection
//                and branch flushing into per-stage enable/bubble controls.
//                Priority: ERR > memory stall > load-use > taken branch.
//  Ports       : clk_i, rst_i (async, active-low)
//                IFID_RSaddr_i, IFID_RTaddr_i, IDEX_RTaddr_i, IDEX_MemRead_i
//                BranchTaken_i, MemReq_i, MemAck_i
//                PCWrite_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o,
//                EXMEM_Hold_o, MEMWB_Bubble_o  (combinational controls)
//                Err_o       - sticky memory timeout error (registered)
//                StallCnt_o  - stall cycle counter (registered)
//  Config      : PIPELINE_CTRL_PERF_EN - when defined, StallCnt_o counts
//                cycles with PCWrite_o=0 (saturating); otherwise tied to 0.
//  Revision    : 1.0  initial release
// ============================================================================
module pipeline_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [c_REG_ADDR_W-1:0] IFID_RSaddr_i,
  input  logic [c_REG_ADDR_W-1:0] IFID_RTaddr_i,
  input  logic [c_REG_ADDR_W-1:0] IDEX_RTaddr_i,
  input  logic                    IDEX_MemRead_i,
  input  logic                    BranchTaken_i,
  input  logic                    MemReq_i,
  input  logic                    MemAck_i,
  output logic                    PCWrite_o,
  output logic                    IFID_Write_o,
  output logic                    IFID_Flush_o,
  output logic                    IDEX_Bubble_o,
  output logic                    EXMEM_Hold_o,
  output logic                    MEMWB_Bubble_o,
  output logic                    Err_o,
  output logic [CNT_W-1:0]        StallCnt_o
);

  // Wait counter must be able to hold MEM_TIMEOUT itself
  localparam int unsigned c_WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(MEM_TIMEOUT);
  localparam logic [c_WAIT_W:0]   c_TIMEOUT  = (c_WAIT_W + 1)'(MEM_TIMEOUT);

  ctrl_state_t         r_state;
  ctrl_state_t         w_next_state;
  logic [c_WAIT_W-1:0] r_wait_cnt;
  logic [c_WAIT_W:0]   w_wait_inc;
  logic                r_err;
  logic                w_mem_stall;
  logic                w_load_use;

  logic w_pc_write;
  logic w_ifid_write;
  logic w_ifid_flush;
  logic w_idex_bubble;
  logic w_exmem_hold;
  logic w_memwb_bubble;

  hazard_detect u_hazard_detect (
    .i_ifid_rs_addr  (IFID_RSaddr_i),
    .i_ifid_rt_addr  (IFID_RTaddr_i),
    .i_idex_rt_addr  (IDEX_RTaddr_i),
    .i_idex_mem_read (IDEX_MemRead_i),
    .o_load_use      (w_load_use)
  );

  // One bit wider so the timeout compare cannot overflow
  assign w_wait_inc = {1'b0, r_wait_cnt} + (c_WAIT_W + 1)'(1);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and memory-stall decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_mem_stall  = 1'b0;
    unique case (r_state)
      ST_RUN: begin
        // A same-cycle ack is a zero-wait access and never leaves RUN
        if (MemReq_i && !MemAck_i) begin
          w_mem_stall  = 1'b1;
          w_next_state = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (MemAck_i) begin
          w_next_state = ST_RUN;
        end else begin
          w_mem_stall = 1'b1;
          // This cycle's increment reaches the limit: give up after it
          if (w_wait_inc >= c_TIMEOUT) begin
            w_next_state = ST_ERR;
          end
        end
      end
      ST_ERR: begin
        w_next_state = ST_ERR;
      end
      default: begin
        w_next_state = ST_RUN;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Wait counter: cleared on entry to WAIT, saturating increment while waiting
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wait_cnt <= '0;
    end else if ((r_state == ST_RUN) && (w_next_state == ST_WAIT)) begin
      r_wait_cnt <= '0;
    end else if ((r_state == ST_WAIT) && !MemAck_i && (r_wait_cnt != c_WAIT_MAX)) begin
      r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
    end
  end

  // Sticky error, set together with the entry into ERR
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_err <= 1'b0;
    end else if (w_next_state == ST_ERR) begin
      r_err <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Pipeline control outputs (priority encoded, zero latency)
  // --------------------------------------------------------------------------
  always_comb begin
    w_pc_write     = 1'b1;
    w_ifid_write   = 1'b1;
    w_ifid_flush   = 1'b0;
    w_idex_bubble  = 1'b0;
    w_exmem_hold   = 1'b0;
    w_memwb_bubble = 1'b0;
    if (r_state == ST_ERR) begin
      w_pc_write     = 1'b0;
      w_ifid_write   = 1'b0;
      w_idex_bubble  = 1'b1;
      w_exmem_hold   = 1'b1;
      w_memwb_bubble = 1'b1;
    end else if (w_mem_stall) begin
      // ID/EX is frozen along with IF/ID upstream, so no bubble here
      w_pc_write     = 1'b0;
      w_ifid_write   = 1'b0;
      w_exmem_hold   = 1'b1;
      w_memwb_bubble = 1'b1;
    end else if (w_load_use) begin
      // A concurrent branch is not flushed; it is re-evaluated next cycle
      w_pc_write    = 1'b0;
      w_ifid_write  = 1'b0;
      w_idex_bubble = 1'b1;
    end else if (BranchTaken_i) begin
      w_ifid_flush = 1'b1;
    end
  end

  assign PCWrite_o      = w_pc_write;
  assign IFID_Write_o   = w_ifid_write;
  assign IFID_Flush_o   = w_ifid_flush;
  assign IDEX_Bubble_o  = w_idex_bubble;
  assign EXMEM_Hold_o   = w_exmem_hold;
  assign MEMWB_Bubble_o = w_memwb_bubble;
  assign Err_o          = r_err;

  // --------------------------------------------------------------------------
  // Optional stall performance counter
  // --------------------------------------------------------------------------
`ifdef PIPELINE_CTRL_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stall_cnt <= '0;
    end else if (!w_pc_write && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign StallCnt_o = r_stall_cnt;
`else
  assign StallCnt_o = '0;
`endif

endmodule : pipeline_ctrl
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_ctrl
//  Description : Directed self-checking bench for pipeline_ctrl. Each step
//                pushes the expected control vector to a scoreboard queue
//                and pops/compares it mid-cycle against the DUT outputs.
//                Honours PIPELINE_CTRL_PERF_EN for the stall counter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipeline_ctrl;

  localparam int unsigned c_CNT_W = 16;

  typedef struct packed {
    logic pc;
    logic ifid_wr;
    logic flush;
    logic idex_bub;
    logic hold;
    logic memwb_bub;
    logic err;
  } exp_t;

  localparam exp_t E_N  = '{pc:1'b1, ifid_wr:1'b1, flush:1'b0, idex_bub:1'b0, hold:1'b0, memwb_bub:1'b0, err:1'b0};
  localparam exp_t E_LU = '{pc:1'b0, ifid_wr:1'b0, flush:1'b0, idex_bub:1'b1, hold:1'b0, memwb_bub:1'b0, err:1'b0};
  localparam exp_t E_BR = '{pc:1'b1, ifid_wr:1'b1, flush:1'b1, idex_bub:1'b0, hold:1'b0, memwb_bub:1'b0, err:1'b0};
  localparam exp_t E_MS = '{pc:1'b0, ifid_wr:1'b0, flush:1'b0, idex_bub:1'b0, hold:1'b1, memwb_bub:1'b1, err:1'b0};
  localparam exp_t E_ER = '{pc:1'b0, ifid_wr:1'b0, flush:1'b0, idex_bub:1'b1, hold:1'b1, memwb_bub:1'b1, err:1'b1};

  logic               clk_i;
  logic               rst_i;
  logic [4:0]         IFID_RSaddr_i;
  logic [4:0]         IFID_RTaddr_i;
  logic [4:0]         IDEX_RTaddr_i;
  logic               IDEX_MemRead_i;
  logic               BranchTaken_i;
  logic               MemReq_i;
  logic               MemAck_i;
  logic               PCWrite_o;
  logic               IFID_Write_o;
  logic               IFID_Flush_o;
  logic               IDEX_Bubble_o;
  logic               EXMEM_Hold_o;
  logic               MEMWB_Bubble_o;
  logic               Err_o;
  logic [c_CNT_W-1:0] StallCnt_o;

  int unsigned        n_total;
  int unsigned        n_pass;
  logic [c_CNT_W-1:0] exp_stall;
  exp_t               exp_q[$];
  string              tag_q[$];

  pipeline_ctrl #(
    .MEM_TIMEOUT (4),
    .CNT_W       (c_CNT_W)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .IFID_RSaddr_i  (IFID_RSaddr_i),
    .IFID_RTaddr_i  (IFID_RTaddr_i),
    .IDEX_RTaddr_i  (IDEX_RTaddr_i),
    .IDEX_MemRead_i (IDEX_MemRead_i),
    .BranchTaken_i  (BranchTaken_i),
    .MemReq_i       (MemReq_i),
    .MemAck_i       (MemAck_i),
    .PCWrite_o      (PCWrite_o),
    .IFID_Write_o   (IFID_Write_o),
    .IFID_Flush_o   (IFID_Flush_o),
    .IDEX_Bubble_o  (IDEX_Bubble_o),
    .EXMEM_Hold_o   (EXMEM_Hold_o),
    .MEMWB_Bubble_o (MEMWB_Bubble_o),
    .Err_o          (Err_o),
    .StallCnt_o     (StallCnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk1(input string tag, input string sig, input logic got, input logic exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s.%s: observed %b expected %b", tag, sig, got, exp);
  endtask

  task automatic chk16(input string tag, input string sig,
                       input logic [c_CNT_W-1:0] got, input logic [c_CNT_W-1:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s.%s: observed %0d expected %0d", tag, sig, got, exp);
  endtask

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] ex_rt,
                        input logic mrd, input logic br, input logic req, input logic ack);
    IFID_RSaddr_i  = rs;
    IFID_RTaddr_i  = rt;
    IDEX_RTaddr_i  = ex_rt;
    IDEX_MemRead_i = mrd;
    BranchTaken_i  = br;
    MemReq_i       = req;
    MemAck_i       = ack;
  endtask

  task automatic expect_out(input string tag, input exp_t e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Pop the oldest expectation and compare it with the current outputs
  task automatic check_now();
    exp_t  e;
    string t;
    n_total++;
    assert (exp_q.size() != 0) n_pass++;
    else begin
      $error("FAIL scoreboard: observed empty queue expected an entry");
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    chk1(t, "PCWrite",     PCWrite_o,      e.pc);
    chk1(t, "IFID_Write",  IFID_Write_o,   e.ifid_wr);
    chk1(t, "IFID_Flush",  IFID_Flush_o,   e.flush);
    chk1(t, "IDEX_Bubble", IDEX_Bubble_o,  e.idex_bub);
    chk1(t, "EXMEM_Hold",  EXMEM_Hold_o,   e.hold);
    chk1(t, "MEMWB_Bubble",MEMWB_Bubble_o, e.memwb_bub);
    chk1(t, "Err",         Err_o,          e.err);
    chk16(t, "StallCnt",   StallCnt_o,     exp_stall);
  endtask

  // One clock cycle: called at posedge+1 with inputs already applied
  task automatic step(input string tag, input exp_t e);
    expect_out(tag, e);
    @(negedge clk_i);
    check_now();
    @(posedge clk_i);
    #1;
`ifdef PIPELINE_CTRL_PERF_EN
    if (!e.pc && rst_i) exp_stall = exp_stall + 16'd1;
`endif
  endtask

  initial begin
    n_total   = 0;
    n_pass    = 0;
    exp_stall = '0;
    rst_i     = 1'b0;
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk_i);
    #1;

    // Reset state
    step("reset", E_N);
    rst_i = 1'b1;
    step("idle", E_N);

    // Load-use on rs, then normal next cycle
    set_in(5'd8, 5'd3, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    step("lu_rs", E_LU);
    set_in(5'd8, 5'd3, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    step("after_lu", E_N);

    // Load-use on rt
    set_in(5'd1, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    step("lu_rt", E_LU);

    // Load into $zero is not a hazard
    set_in(5'd4, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("zero_load", E_N);

    // Address match without a load
    set_in(5'd8, 5'd3, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    step("no_load", E_N);

    // Branch alone, then load-use plus branch
    set_in(5'd2, 5'd3, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0);
    step("branch", E_BR);
    set_in(5'd8, 5'd3, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
    step("lu_branch", E_LU);

    // Memory wait: three stalled cycles, ack on the fourth
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("mw_run", E_MS);
    step("mw_wait1", E_MS);
    step("mw_wait2", E_MS);
    MemAck_i = 1'b1;
    step("mw_ack", E_N);
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("mw_done", E_N);

    // Zero-wait access stays in RUN (no stall on the following idle cycle)
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    step("zero_wait", E_N);
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("zero_wait_after", E_N);

    // Memory stall dominates load-use and branch; load-use shows once ack arrives
    set_in(5'd8, 5'd3, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0);
    step("ms_lu", E_MS);
    set_in(5'd8, 5'd3, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1);
    step("ack_lu", E_LU);
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("ms_lu_done", E_N);

    // Timeout: four WAIT cycles without ack, then ERR
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("to_run", E_MS);
    step("to_wait1", E_MS);
    step("to_wait2", E_MS);
    step("to_wait3", E_MS);
    step("to_wait4", E_MS);
    step("to_err", E_ER);
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("err_ack", E_ER);
    set_in(5'd8, 5'd3, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
    step("err_sticky", E_ER);

    // Reset out of ERR between clock edges
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    rst_i     = 1'b0;
    exp_stall = '0;
    #1;
    expect_out("err_reset", E_N);
    check_now();
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    step("post_err_reset", E_N);

    // Reset mid-WAIT between clock edges
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("rw_run", E_MS);
    step("rw_wait1", E_MS);
    MemReq_i = 1'b0;
    #1;
    expect_out("rw_wait2", E_MS);
    check_now();
    #1;
    rst_i     = 1'b0;
    exp_stall = '0;
    #1;
    expect_out("rw_reset", E_N);
    check_now();
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    step("rw_after", E_N);
    step("rw_after2", E_N);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_pipeline_ctrl
`default_nettype wire
